ubi_s2b_win: RTL and testbench

Windowed bipolar stochastic-to-binary converter placed directly downstream of the 16-input scaled bipolar MAC. It counts ones on the MAC's single-bit output stream over a fixed window of 2^CWIDTH cycles. It converts the count to a signed bipolar value and undoes the 1/16 scaling of the scaled adder. Results are presented through a valid/ready handshake to the binary-domain consumer.

---
 rtl/ustoch_pkg.sv | 15 +
 rtl/ubi_s2b_win_uones_cnt.sv | 42 ++++
 rtl/ubi_s2b_win.sv | 141 ++++++++++++++
 tb/tb_ubi_s2b_win.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ustoch_pkg.sv
// Shared definitions for the stochastic-to-binary conversion stages.
// Holds the converter FSM encoding and the MAC fan-in scaling constants.
package ustoch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SKIP = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } ubi_s2b_state_t;

  localparam int MAC_FANIN      = 16;
  localparam int SCALE_LOG2_DEF = $clog2(MAC_FANIN);

endpackage

// File: rtl/ubi_s2b_win_uones_cnt.sv
// Parameterised ones counter for stochastic bitstreams with synchronous clear/enable.
// Also exposes the value the counter will hold after the current edge.
module uones_cnt #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         bit_in,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_nxt
);

  logic [W-1:0] cnt_r;
  logic [W-1:0] inc_s;

  // Increment amount: one only when enabled and the stream bit is set.
  always_comb begin
    inc_s = {W{1'b0}};
    if (en && bit_in) begin
      inc_s = {{(W-1){1'b0}}, 1'b1};
    end else begin
      inc_s = {W{1'b0}};
    end
  end

  // Ones count register; clear wins over counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {W{1'b0}};
    end else if (clr) begin
      cnt_r <= {W{1'b0}};
    end else begin
      cnt_r <= cnt_r + inc_s;
    end
  end

  assign cnt     = cnt_r;
  assign cnt_nxt = cnt_r + inc_s;

endmodule

// File: rtl/ubi_s2b_win.sv
// Windowed bipolar stochastic-to-binary converter behind the scaled 16-input MAC.
// Counts ones over 2^CWIDTH samples and presents count, bipolar and unscaled values.
module ubi_s2b_win
  import ustoch_pkg::*;
#(
  parameter int CWIDTH     = 8,
  parameter int SKIP       = 2,
  parameter int SCALE_LOG2 = SCALE_LOG2_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                iBit,
  input  logic                                start,
  output logic                                oBusy,
  output logic                                oValid,
  input  logic                                oReady,
  output logic [CWIDTH:0]                     oCnt,
  output logic signed [CWIDTH+1:0]            oVal,
  output logic signed [CWIDTH+1+SCALE_LOG2:0] oScaled
);

  localparam logic [3:0]        SKIP_LAST = SKIP[3:0] - 4'd1;
  localparam bit                HAS_SKIP  = (SKIP != 0);
  localparam logic [CWIDTH+1:0] WIN_LEN   = {2'b01, {CWIDTH{1'b0}}};

  ubi_s2b_state_t state_r;
  logic [3:0]                         skip_r;
  logic [CWIDTH-1:0]                  win_r;
  logic                               busy_r;
  logic                               valid_r;
  logic [CWIDTH:0]                    cnt_r;
  logic signed [CWIDTH+1:0]           val_r;
  logic signed [CWIDTH+1+SCALE_LOG2:0] scaled_r;

  logic                               go_s;
  logic                               run_s;
  logic                               win_last_s;
  logic [CWIDTH:0]                    ones_s;
  logic [CWIDTH:0]                    ones_nxt_s;
  logic signed [CWIDTH+1:0]           val_nxt_s;
  logic signed [CWIDTH+1+SCALE_LOG2:0] scaled_nxt_s;

  // Start acceptance: IDLE, or DONE when the result is taken the same cycle.
  always_comb begin
    go_s = 1'b0;
    case (state_r)
      ST_IDLE: go_s = start;
      ST_DONE: go_s = start && oReady;
      default: go_s = 1'b0;
    endcase
  end

  // Window bookkeeping and the result as it will look after the final sample.
  always_comb begin
    run_s        = (state_r == ST_RUN);
    win_last_s   = (win_r == {CWIDTH{1'b1}});
    val_nxt_s    = $signed({ones_nxt_s, 1'b0} - WIN_LEN);
    scaled_nxt_s = {val_nxt_s, {SCALE_LOG2{1'b0}}};
  end

  uones_cnt #(
    .W (CWIDTH + 1)
  ) u_ones (
    .clk     (clk),
    .rst     (rst),
    .clr     (go_s),
    .en      (run_s),
    .bit_in  (iBit),
    .cnt     (ones_s),
    .cnt_nxt (ones_nxt_s)
  );

  // Converter FSM with window/skip counters and registered results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      skip_r   <= 4'd0;
      win_r    <= {CWIDTH{1'b0}};
      busy_r   <= 1'b0;
      valid_r  <= 1'b0;
      cnt_r    <= {(CWIDTH+1){1'b0}};
      val_r    <= {(CWIDTH+2){1'b0}};
      scaled_r <= {(CWIDTH+2+SCALE_LOG2){1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (go_s) begin
            state_r <= HAS_SKIP ? ST_SKIP : ST_RUN;
            skip_r  <= 4'd0;
            win_r   <= {CWIDTH{1'b0}};
            busy_r  <= 1'b1;
            valid_r <= 1'b0;
          end
        end
        ST_SKIP: begin
          if (skip_r == SKIP_LAST) begin
            state_r <= ST_RUN;
          end else begin
            skip_r <= skip_r + 4'd1;
          end
        end
        ST_RUN: begin
          win_r <= win_r + {{(CWIDTH-1){1'b0}}, 1'b1};
          // The window counter wraps on the last sample; latch the result on that edge.
          if (win_last_s) begin
            state_r  <= ST_DONE;
            busy_r   <= 1'b0;
            valid_r  <= 1'b1;
            cnt_r    <= ones_nxt_s;
            val_r    <= val_nxt_s;
            scaled_r <= scaled_nxt_s;
          end
        end
        ST_DONE: begin
          if (go_s) begin
            state_r <= HAS_SKIP ? ST_SKIP : ST_RUN;
            skip_r  <= 4'd0;
            win_r   <= {CWIDTH{1'b0}};
            busy_r  <= 1'b1;
            valid_r <= 1'b0;
          end else if (oReady) begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign oBusy   = busy_r;
  assign oValid  = valid_r;
  assign oCnt    = cnt_r;
  assign oVal    = val_r;
  assign oScaled = scaled_r;

endmodule

// File: tb/tb_ubi_s2b_win.sv
// Self-checking bench for ubi_s2b_win: directed and random windows against a count model.
// A second small instance covers the CWIDTH=4, SKIP=0 configuration.
module tb_ubi_s2b_win;

  localparam int CW  = 8;
  localparam int SK  = 2;
  localparam int SL  = 4;
  localparam int WIN = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic                    i_bit = 1'b0;
  logic                    start = 1'b0;
  logic                    o_ready = 1'b0;
  logic                    busy;
  logic                    valid;
  logic [CW:0]             cnt;
  logic signed [CW+1:0]    val;
  logic signed [CW+1+SL:0] scaled;

  logic                    s_bit = 1'b0;
  logic                    s_start = 1'b0;
  logic                    s_ready = 1'b0;
  logic                    s_busy;
  logic                    s_valid;
  logic [4:0]              s_cnt;
  logic signed [5:0]       s_val;
  logic signed [9:0]       s_scaled;

  int errors = 0;
  int checks = 0;
  int exp_cnt_g = 0;
  bit bits [0:1023];

  always #5 clk = ~clk;

  ubi_s2b_win #(.CWIDTH(CW), .SKIP(SK), .SCALE_LOG2(SL)) dut (
    .clk(clk), .rst(rst), .iBit(i_bit), .start(start), .oBusy(busy), .oValid(valid),
    .oReady(o_ready), .oCnt(cnt), .oVal(val), .oScaled(scaled)
  );

  ubi_s2b_win #(.CWIDTH(4), .SKIP(0), .SCALE_LOG2(SL)) dut_s (
    .clk(clk), .rst(rst), .iBit(s_bit), .start(s_start), .oBusy(s_busy), .oValid(s_valid),
    .oReady(s_ready), .oCnt(s_cnt), .oVal(s_val), .oScaled(s_scaled)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Launch a conversion at the current negedge and check the result against the model.
  task automatic run_conv(input string tag, input bit b2b);
    int k;
    int ec;
    ec = 0;
    for (int i = 0; i < WIN; i++) ec += int'(bits[SK + i]);
    exp_cnt_g = ec;
    start = 1'b1;
    o_ready = b2b;
    @(negedge clk);
    k = 1;
    start = 1'b0;
    o_ready = 1'b0;
    chk({tag, "_busy_rise"}, busy, 1);
    chk({tag, "_valid_low"}, valid, 0);
    i_bit = bits[0];
    while (valid !== 1'b1 && k < 700) begin
      @(negedge clk);
      k++;
      if (valid !== 1'b1) i_bit = bits[k - 1];
    end
    chk({tag, "_latency"}, k, SK + WIN + 1);
    chk({tag, "_cnt"}, cnt, ec);
    chk({tag, "_val"}, val, 2 * ec - WIN);
    chk({tag, "_scaled"}, scaled, (2 * ec - WIN) * (1 << SL));
    chk({tag, "_busy_done"}, busy, 0);
  endtask

  task automatic accept(input string tag);
    o_ready = 1'b1;
    @(negedge clk);
    o_ready = 1'b0;
    chk({tag, "_acc_valid"}, valid, 0);
    chk({tag, "_acc_busy"}, busy, 0);
    chk({tag, "_acc_hold"}, cnt, exp_cnt_g);
  endtask

  initial begin
    int k;
    int hold_cnt;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_val", val, 0);
    chk("rst_scaled", scaled, 0);
    chk("rst_s_valid", s_valid, 0);
    chk("rst_s_cnt", s_cnt, 0);

    for (int i = 0; i < 1024; i++) bits[i] = 1'b1;
    run_conv("ones", 1'b0);
    accept("ones");

    for (int i = 0; i < 1024; i++) bits[i] = 1'b0;
    run_conv("zeros", 1'b0);
    accept("zeros");

    // Ones during the skip cycles must not be counted.
    for (int i = 0; i < 1024; i++) bits[i] = (i < SK) ? 1'b1 : ((i - SK) % 2 == 0);
    run_conv("skipdisc", 1'b0);
    accept("skipdisc");

    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 1024; i++) bits[i] = 1'($urandom);
      run_conv("rand", 1'b0);
      accept("rand");
    end

    for (int i = 0; i < 1024; i++) bits[i] = ($urandom_range(3, 0) == 0);
    run_conv("hold", 1'b0);
    hold_cnt = exp_cnt_g;
    for (int c = 0; c < 10; c++) begin
      start = (c == 4);
      @(negedge clk);
      start = 1'b0;
      chk("hold_valid", valid, 1);
      chk("hold_busy", busy, 0);
      chk("hold_cnt", cnt, hold_cnt);
    end
    for (int i = 0; i < 1024; i++) bits[i] = 1'($urandom);
    run_conv("b2b", 1'b1);
    accept("b2b");

    for (int i = 0; i < 1024; i++) bits[i] = 1'b1;
    run_conv("pre_rst", 1'b0);
    accept("pre_rst");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (k = 1; k < SK + 100; k++) begin
      i_bit = 1'b1;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", valid, 0);
    chk("midrst_cnt", cnt, 0);
    chk("midrst_val", val, 0);
    chk("midrst_scaled", scaled, 0);
    repeat (5) @(negedge clk);
    chk("midrst_idle_busy", busy, 0);
    chk("midrst_idle_valid", valid, 0);
    for (int i = 0; i < 1024; i++) bits[i] = 1'($urandom);
    run_conv("after_rst", 1'b0);
    accept("after_rst");

    // Small window: 12 ones then zeros over a 16-sample window with no skip.
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    k = 1;
    s_bit = 1'b1;
    chk("small_busy", s_busy, 1);
    while (s_valid !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
      s_bit = (k - 1 < 12);
    end
    chk("small_latency", k, 17);
    chk("small_cnt", s_cnt, 12);
    chk("small_val", s_val, 2 * 12 - 16);
    chk("small_scaled", s_scaled, (2 * 12 - 16) * (1 << SL));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
